// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth multiplier issue controller.
// Holds the controller state encoding, default operand width and WAIT timeout length.
// The timeout length is also available as a function so other widths can reuse it.
package booth_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_LDM   = 3'd2,
    ST_LDQ   = 3'd3,
    ST_WAIT  = 3'd4,
    ST_RESP  = 3'd5,
    ST_CLR   = 3'd6
  } state_t;

  // Radix-2 Booth needs about one cycle per operand bit on each phase, plus slack.
  function automatic int timeout_cycles(input int width);
    return 2 * width + 4;
  endfunction

  localparam int TIMEOUT_CYCLES = timeout_cycles(DEFAULT_WIDTH);

endpackage

// File: rtl/booth_wait_timer.sv
// Loadable down-counter that flags expiry once it has reached zero.
// Latency: load takes effect on the next edge; expired_o is combinational from the count.
// Backpressure: none; counting pauses at zero and whenever en_i is low.
module booth_wait_timer #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          en_i,
  output logic          expired_o
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Load has priority over counting; the count saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  // Count register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/booth_issue_ctrl.sv
// Issues operand pairs to a Booth multiplier (start, mcand load, mplier load) and returns the product.
// Latency: accept-to-accept is at least 6 cycles plus multiplier latency plus out_ready stall cycles.
// Backpressure: one transaction in flight; in_ready only in IDLE, RESP holds until out_ready.
// Optional build macro BOOTH_ISSUE_TIMEOUT_EN adds a WAIT watchdog that returns out_err=1.
module booth_issue_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_mcand,
  input  logic [WIDTH-1:0]   in_mplier,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_data,
  output logic               mul_clr,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_product,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic               out_err,
  output logic               busy
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mplier_q;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               accept;

  assign accept = in_valid & in_ready;

`ifdef BOOTH_ISSUE_TIMEOUT_EN
  localparam int              TO_CYCLES = timeout_cycles(WIDTH);
  localparam int              TW        = $clog2(TO_CYCLES + 1);
  // Loaded while in LDQ so the count reads TO_CYCLES-1 on the first WAIT cycle
  // and hits zero on the last permitted WAIT cycle.
  localparam logic [TW-1:0]   TO_LOAD   = TW'(TO_CYCLES - 1);

  logic tmr_expired;
  logic timeout;
  logic err_q, err_d;

  booth_wait_timer #(
    .CW (TW)
  ) u_wait_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (state_q == ST_LDQ),
    .load_val_i (TO_LOAD),
    .en_i       (state_q == ST_WAIT),
    .expired_o  (tmr_expired)
  );

  assign timeout = (state_q == ST_WAIT) & tmr_expired;
  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

  // Next-state and result-capture logic; mul_done only matters in WAIT.
  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
`ifdef BOOTH_ISSUE_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_START;
      ST_START: state_d = ST_LDM;
      ST_LDM:   state_d = ST_LDQ;
      ST_LDQ:   state_d = ST_WAIT;
      ST_WAIT: begin
        if (mul_done) begin
          state_d = ST_RESP;
          prod_d  = mul_product;
`ifdef BOOTH_ISSUE_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (timeout) begin
          state_d = ST_RESP;
          prod_d  = '0;
          err_d   = 1'b1;
`endif
        end
      end
      ST_RESP:  if (out_ready) state_d = ST_CLR;
      ST_CLR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and captured-result registers; reset discards any pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
    end
  end

`ifdef BOOTH_ISSUE_TIMEOUT_EN
  // Error flag travels with the captured product.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

  // Operand latches only load on an accepted handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (accept) begin
      mcand_q  <= in_mcand;
      mplier_q <= in_mplier;
    end
  end

  // Shared load bus: multiplicand then multiplier, zero otherwise.
  always_comb begin
    mul_data = '0;
    if (state_q == ST_LDM) mul_data = mcand_q;
    if (state_q == ST_LDQ) mul_data = mplier_q;
  end

  assign in_ready    = (state_q == ST_IDLE) & ~rst;
  assign mul_start   = (state_q == ST_START);
  // Held during reset so the multiplier always leaves its terminal state.
  assign mul_clr     = rst | (state_q == ST_CLR);
  assign out_valid   = (state_q == ST_RESP);
  assign out_product = prod_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
